chess_board_store: RTL and testbench

Parametrised board storage for the chess datapath. It replaces the flat board register array and the single-cycle initial-position preset in the top level. It holds ROWS×COLS piece codes and exposes them as a flattened bus to the game logic and the display interface. It adds three things:
- a sequenced initial-position load;
- a guarded write port;
- a bounded move-history stack that supports multi-square undo.

---
 rtl/chess_pkg.sv | 63 ++++++
 rtl/chess_hist_stack.sv | 65 ++++++
 rtl/chess_board_store.sv | 183 ++++++++++++++++++
 tb/tb_chess_board_store.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared definitions for the chess board datapath: piece codes, FSM state
// encoding and the initial-position generator.
package chess_pkg;

    // Piece types (low three bits of a square code)
    localparam logic [2:0] EMPTY  = 3'b000;
    localparam logic [2:0] PAWN   = 3'b001;
    localparam logic [2:0] KNIGHT = 3'b010;
    localparam logic [2:0] BISHOP = 3'b011;
    localparam logic [2:0] ROOK   = 3'b100;
    localparam logic [2:0] QUEEN  = 3'b101;
    localparam logic [2:0] KING   = 3'b110;

    // Colour bit position within the canonical 4-bit code returned by init_val
    localparam int COLOUR_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_UNDO = 2'd2
    } state_e;

    // Back-rank piece for an 8-wide board, indexed by column
    function automatic logic [2:0] back_rank(input int col);
        logic [2:0] t;
        case (col)
            0, 7:    t = ROOK;
            1, 6:    t = KNIGHT;
            2, 5:    t = BISHOP;
            3:       t = QUEEN;
            4:       t = KING;
            default: t = EMPTY;
        endcase
        return t;
    endfunction

    // Starting-position code for square idx as {colour, type}. Colour 1
    // occupies rows 0/1, colour 0 occupies the last two rows. Boards that are
    // not 8 columns wide get pawns only.
    function automatic logic [3:0] init_val(input int idx, input int rows, input int cols);
        int         row;
        int         col;
        logic [2:0] typ;
        logic       colour;
        row    = idx / cols;
        col    = idx % cols;
        typ    = EMPTY;
        colour = 1'b0;
        if (row == rows - 1) begin
            typ = (cols == 8) ? back_rank(col) : EMPTY;
        end else if (row == rows - 2) begin
            typ = PAWN;
        end else if (row == 1) begin
            colour = 1'b1;
            typ    = PAWN;
        end else if (row == 0) begin
            colour = 1'b1;
            typ    = (cols == 8) ? back_rank(col) : EMPTY;
        end
        return {colour, typ};
    endfunction

endpackage

// File: rtl/chess_hist_stack.sv
// LIFO ring of history entries. A push onto a full stack overwrites the
// oldest entry (the pointer simply wraps), so the newest DEPTH entries are
// always the ones available to pop. DEPTH must be a power of two.
module chess_hist_stack #(
    parameter  int DEPTH = 16,
    parameter  int DW    = 11,
    localparam int PW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [DW-1:0]    push_data_i,
    output logic [DW-1:0]    top_data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    ptr_q;       // next free slot; top of stack is ptr_q-1
    logic [PW-1:0]    ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Entry storage: written on push only, never reset
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

    // Next pointer/count: clear beats push, push beats pop, count saturates
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (clear_i) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (push_i) begin
            ptr_d = ptr_q + PW'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_i && (count_q != '0)) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign top_data_o = mem_q[ptr_q - PW'(1)];
    assign count_o    = count_q;

endmodule

// File: rtl/chess_board_store.sv
// Board storage for the chess datapath: sequenced initial-position load,
// guarded single-square writes and multi-square undo from a bounded history.
// Each history entry is {addr, previous piece, first-of-move flag}; undo pops
// entries until it restores the one that opened the move group.
module chess_board_store
    import chess_pkg::*;
#(
    parameter  int ROWS       = 8,
    parameter  int COLS       = 8,
    parameter  int PIECE_W    = 4,
    parameter  int HIST_DEPTH = 16,
    localparam int SQ         = ROWS * COLS,
    localparam int ADDR_W     = $clog2(SQ),
    localparam int HCNT_W     = $clog2(HIST_DEPTH + 1)
) (
    input  logic                  clk_25MHz,
    input  logic                  Reset,
    input  logic                  init_req,
    input  logic                  wr_en,
    input  logic                  wr_first,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [PIECE_W-1:0]    wr_piece,
    input  logic                  undo_req,
    output logic [SQ*PIECE_W-1:0] board_flat,
    output logic                  busy,
    output logic [HCNT_W-1:0]     hist_count,
    output logic                  undo_err
);

    localparam int                EW       = ADDR_W + PIECE_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SQ - 1);

    // Map the canonical 4-bit {colour, type} code onto PIECE_W bits
    function automatic logic [PIECE_W-1:0] to_code(input logic [3:0] v);
        logic [PIECE_W-1:0] r;
        r              = PIECE_W'(v[2:0]);
        r[PIECE_W-1]   = v[COLOUR_BIT];
        return r;
    endfunction

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   idx_d;
    logic                undo_err_q;
    logic                undo_err_d;
    logic [PIECE_W-1:0]  board_q [SQ];

    logic                sq_we;
    logic [ADDR_W-1:0]   sq_addr;
    logic [PIECE_W-1:0]  sq_data;

    logic                h_push;
    logic                h_pop;
    logic                h_clear;
    logic [EW-1:0]       h_push_data;
    logic [EW-1:0]       h_top;
    logic [HCNT_W-1:0]   h_count;

    logic                addr_ok;
    logic [ADDR_W-1:0]   top_addr;
    logic [PIECE_W-1:0]  top_old;
    logic                top_first;

    assign addr_ok     = ({1'b0, wr_addr} < (ADDR_W + 1)'(SQ));
    assign h_push_data = {wr_addr, board_q[wr_addr], wr_first};
    assign top_addr    = h_top[EW-1 -: ADDR_W];
    assign top_old     = h_top[PIECE_W:1];
    assign top_first   = h_top[0];

    chess_hist_stack #(
        .DEPTH (HIST_DEPTH),
        .DW    (EW)
    ) u_hist (
        .clk_i       (clk_25MHz),
        .rst_i       (Reset),
        .clear_i     (h_clear),
        .push_i      (h_push),
        .pop_i       (h_pop),
        .push_data_i (h_push_data),
        .top_data_o  (h_top),
        .count_o     (h_count)
    );

    // Next state and the single square-write port; init_req overrides any state
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        undo_err_d = 1'b0;
        sq_we      = 1'b0;
        sq_addr    = idx_q;
        sq_data    = '0;
        h_push     = 1'b0;
        h_pop      = 1'b0;
        h_clear    = 1'b0;
        if (init_req) begin
            state_d = ST_INIT;
            idx_d   = '0;
            h_clear = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sq_we   = 1'b1;
                    sq_addr = idx_q;
                    sq_data = to_code(init_val(int'(idx_q), ROWS, COLS));
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    // A write always wins over a same-cycle undo request
                    if (wr_en) begin
                        if (addr_ok) begin
                            sq_we   = 1'b1;
                            sq_addr = wr_addr;
                            sq_data = wr_piece;
                            h_push  = 1'b1;
                        end
                    end else if (undo_req) begin
                        if (h_count == '0) begin
                            undo_err_d = 1'b1;
                        end else begin
                            state_d = ST_UNDO;
                        end
                    end
                end
                ST_UNDO: begin
                    if (h_count == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        h_pop   = 1'b1;
                        sq_we   = 1'b1;
                        sq_addr = top_addr;
                        sq_data = top_old;
                        if (top_first || (h_count == HCNT_W'(1))) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, load index and error pulse registers; reset starts a fresh load
    always_ff @(posedge clk_25MHz) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            idx_q      <= '0;
            undo_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            undo_err_q <= undo_err_d;
        end
    end

    // Square registers: cleared on reset, otherwise one write per cycle
    always_ff @(posedge clk_25MHz) begin
        if (Reset) begin
            for (int i = 0; i < SQ; i++) begin
                board_q[i] <= '0;
            end
        end else if (sq_we) begin
            board_q[sq_addr] <= sq_data;
        end
    end

    // Flatten the square registers onto the output bus
    always_comb begin
        board_flat = '0;
        for (int i = 0; i < SQ; i++) begin
            board_flat[i*PIECE_W +: PIECE_W] = board_q[i];
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign hist_count = h_count;
    assign undo_err   = undo_err_q;

endmodule

// File: tb/tb_chess_board_store.sv
// Bench for chess_board_store at default parameters. A board/history model
// built from the game rules (array of squares, queue of history entries) is
// compared against every output on every falling edge; directed sequences add
// hand-computed literal expectations.
module tb_chess_board_store;

    localparam int SQ  = 64;
    localparam int PW  = 4;
    localparam int AW  = 6;
    localparam int HD  = 16;
    localparam int EW  = AW + PW + 1;
    localparam logic [2:0] BACK [8] = '{3'b100, 3'b010, 3'b011, 3'b101,
                                        3'b110, 3'b011, 3'b010, 3'b100};

    logic              clk_25MHz = 1'b0;
    logic              Reset     = 1'b1;
    logic              init_req  = 1'b0;
    logic              wr_en     = 1'b0;
    logic              wr_first  = 1'b0;
    logic [AW-1:0]     wr_addr   = '0;
    logic [PW-1:0]     wr_piece  = '0;
    logic              undo_req  = 1'b0;
    logic [SQ*PW-1:0]  board_flat;
    logic              busy;
    logic [4:0]        hist_count;
    logic              undo_err;

    int n_checks = 0;
    int n_pass   = 0;

    chess_board_store dut (
        .clk_25MHz  (clk_25MHz),
        .Reset      (Reset),
        .init_req   (init_req),
        .wr_en      (wr_en),
        .wr_first   (wr_first),
        .wr_addr    (wr_addr),
        .wr_piece   (wr_piece),
        .undo_req   (undo_req),
        .board_flat (board_flat),
        .busy       (busy),
        .hist_count (hist_count),
        .undo_err   (undo_err)
    );

    // Clock
    always #20 clk_25MHz = ~clk_25MHz;

    // ---------------- scoreboard / model ----------------
    logic [PW-1:0] m_board [SQ];
    logic [EW-1:0] exp_q [$];      // history, newest at the back
    int            m_mode  = 0;    // 0 idle, 1 loading, 2 undoing
    int            m_lidx  = 0;
    logic          m_err   = 1'b0;
    bit            check_en = 1'b0;

    function automatic logic [3:0] init_sq(input int i);
        int row;
        int col;
        row = i / 8;
        col = i % 8;
        if (row == 7) return {1'b0, BACK[col]};
        if (row == 6) return 4'b0001;
        if (row == 1) return 4'b1001;
        if (row == 0) return {1'b1, BACK[col]};
        return 4'b0000;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] sq(input int i);
        return board_flat[i*PW +: PW];
    endfunction

    // Model update at each rising edge from the same inputs the DUT sees
    initial forever begin
        logic [EW-1:0] e;
        @(posedge clk_25MHz);
        if (Reset) begin
            for (int i = 0; i < SQ; i++) m_board[i] = '0;
            exp_q.delete();
            m_mode   = 1;
            m_lidx   = 0;
            m_err    = 1'b0;
            check_en = 1'b1;
        end else begin
            m_err = 1'b0;
            if (init_req) begin
                m_mode = 1;
                m_lidx = 0;
                exp_q.delete();
            end else if (m_mode == 1) begin
                m_board[m_lidx] = init_sq(m_lidx);
                if (m_lidx == SQ - 1) m_mode = 0;
                else m_lidx++;
            end else if (m_mode == 0) begin
                if (wr_en) begin
                    if (int'(wr_addr) < SQ) begin
                        exp_q.push_back({wr_addr, m_board[wr_addr], wr_first});
                        if (exp_q.size() > HD) e = exp_q.pop_front();
                        m_board[wr_addr] = wr_piece;
                    end
                end else if (undo_req) begin
                    if (exp_q.size() == 0) m_err = 1'b1;
                    else m_mode = 2;
                end
            end else begin
                if (exp_q.size() == 0) begin
                    m_mode = 0;
                end else begin
                    e = exp_q.pop_back();
                    m_board[e[EW-1 -: AW]] = e[PW:1];
                    if (e[0] || exp_q.size() == 0) m_mode = 0;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge
    initial forever begin
        logic [SQ*PW-1:0] exp_flat;
        @(negedge clk_25MHz);
        if (check_en) begin
            for (int i = 0; i < SQ; i++) exp_flat[i*PW +: PW] = m_board[i];
            check("board_flat", 256'(board_flat), 256'(exp_flat));
            check("busy", 256'(busy), 256'(m_mode != 0));
            check("hist_count", 256'(hist_count), 256'(exp_q.size()));
            check("undo_err", 256'(undo_err), 256'(m_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk_25MHz);
        #1;
    endtask

    task automatic wr(input logic f, input logic [AW-1:0] a, input logic [PW-1:0] p);
        wr_en    = 1'b1;
        wr_first = f;
        wr_addr  = a;
        wr_piece = p;
        tick();
        wr_en    = 1'b0;
        wr_first = 1'b0;
    endtask

    task automatic undo_count(output int cnt);
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic wait_load(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (busy && cyc < 200);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int c;
        repeat (3) tick();
        Reset = 1'b0;

        // Initial load
        wait_load(c);
        check("load_cycles", 256'(c), 256'(64));
        check("sq0",  256'(sq(0)),  256'(4'b1100));
        check("sq4",  256'(sq(4)),  256'(4'b1110));
        check("sq9",  256'(sq(9)),  256'(4'b1001));
        check("sq60", 256'(sq(60)), 256'(4'b0110));
        check("sq63", 256'(sq(63)), 256'(4'b0100));
        check("sq27", 256'(sq(27)), 256'(4'b0000));
        check("hist_after_load", 256'(hist_count), 256'(0));

        // Two-square move and its undo
        wr(1'b1, 6'd52, 4'b0000);
        wr(1'b0, 6'd36, 4'b0001);
        check("mv_sq52", 256'(sq(52)), 256'(4'b0000));
        check("mv_sq36", 256'(sq(36)), 256'(4'b0001));
        check("mv_hist", 256'(hist_count), 256'(2));
        undo_count(c);
        check("undo2_busy_cycles", 256'(c), 256'(2));
        check("undo_sq52", 256'(sq(52)), 256'(4'b0001));
        check("undo_sq36", 256'(sq(36)), 256'(4'b0000));
        check("undo_hist", 256'(hist_count), 256'(0));

        // Capture and undo
        wr(1'b1, 6'd44, 4'b0001);
        wr(1'b1, 6'd12, 4'b0000);
        wr(1'b0, 6'd44, 4'b1001);
        check("cap_sq44", 256'(sq(44)), 256'(4'b1001));
        check("cap_hist", 256'(hist_count), 256'(3));
        undo_count(c);
        check("cap_undo_cycles", 256'(c), 256'(2));
        check("cap_undo_sq12", 256'(sq(12)), 256'(4'b1001));
        check("cap_undo_sq44", 256'(sq(44)), 256'(4'b0001));
        check("cap_undo_hist", 256'(hist_count), 256'(1));
        undo_count(c);
        check("preload_undo_sq44", 256'(sq(44)), 256'(4'b0000));

        // Undo with empty history
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
        check("empty_undo_err", 256'(undo_err), 256'(1));
        check("empty_undo_busy", 256'(busy), 256'(0));
        tick();
        check("empty_undo_err_drop", 256'(undo_err), 256'(0));

        // Saturating history
        for (int i = 0; i < 20; i++) wr(1'b1, 6'(16 + i), 4'((i % 7) + 1));
        check("sat_hist", 256'(hist_count), 256'(16));
        for (int k = 0; k < 16; k++) begin
            undo_count(c);
            check("sat_undo_cycles", 256'(c), 256'(1));
        end
        check("sat_sq16", 256'(sq(16)), 256'(4'd1));
        check("sat_sq19", 256'(sq(19)), 256'(4'd4));
        check("sat_sq20", 256'(sq(20)), 256'(4'd0));
        check("sat_sq35", 256'(sq(35)), 256'(4'd0));
        check("sat_hist_empty", 256'(hist_count), 256'(0));
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
        check("sat_17th_undo_err", 256'(undo_err), 256'(1));

        // init_req during UNDO
        wr(1'b1, 6'd50, 4'b0000);
        wr(1'b0, 6'd42, 4'b0001);
        wr(1'b0, 6'd34, 4'b0001);
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
        check("undo_started", 256'(busy), 256'(1));
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        check("init_in_undo_hist", 256'(hist_count), 256'(0));
        wait_load(c);
        check("reload_cycles", 256'(c), 256'(64));
        check("reload_sq50", 256'(sq(50)), 256'(4'b0001));
        check("reload_sq42", 256'(sq(42)), 256'(4'b0000));
        check("reload_sq0", 256'(sq(0)), 256'(4'b1100));

        // Write together with undo: write wins, no undo follows
        wr_en    = 1'b1;
        wr_first = 1'b1;
        wr_addr  = 6'd40;
        wr_piece = 4'b0101;
        undo_req = 1'b1;
        tick();
        wr_en    = 1'b0;
        wr_first = 1'b0;
        undo_req = 1'b0;
        check("wr_undo_sq40", 256'(sq(40)), 256'(4'b0101));
        check("wr_undo_busy", 256'(busy), 256'(0));
        check("wr_undo_hist", 256'(hist_count), 256'(1));
        tick();
        check("wr_undo_no_late_undo", 256'(busy), 256'(0));
        undo_count(c);
        check("wr_undo_cleanup_sq40", 256'(sq(40)), 256'(4'b0000));

        // Reset in the middle of a load
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (10) tick();
        Reset = 1'b1;
        tick();
        check("midreset_sq0", 256'(sq(0)), 256'(4'b0000));
        check("midreset_sq9", 256'(sq(9)), 256'(4'b0000));
        check("midreset_busy", 256'(busy), 256'(1));
        Reset = 1'b0;
        wait_load(c);
        check("midreset_reload_cycles", 256'(c), 256'(64));
        check("midreset_sq0_loaded", 256'(sq(0)), 256'(4'b1100));
        check("midreset_sq63_loaded", 256'(sq(63)), 256'(4'b0100));

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
